// File: rtl/led_cube_pkg.sv
// rtl/led_cube_pkg.sv - shared LED cube layer-path types and constants
//
// Purpose: constants and types shared by the layer-request encoder and the
//          layer select decoder.
// Contents:
//   CODE_W, NUM_LAYERS                          layer code width / layer count
//   DEFAULT_BLANK_CYCLES, DEFAULT_DWELL_CYCLES  default slot timing
//   layer_state_t                               decoder slot FSM states
//   cnt_width()                                 width of the blank/dwell counter
package led_cube_pkg;

    localparam int CODE_W               = 3;
    localparam int NUM_LAYERS           = 2 ** CODE_W;
    localparam int DEFAULT_BLANK_CYCLES = 4;
    localparam int DEFAULT_DWELL_CYCLES = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } layer_state_t;

    // One counter serves both intervals, so it must hold the larger load value.
    function automatic int cnt_width(input int blank_cycles, input int dwell_cycles);
        int max_v;
        max_v = (blank_cycles > dwell_cycles) ? blank_cycles : dwell_cycles;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/layer_onehot_dec.sv
// rtl/layer_onehot_dec.sv - combinational layer code to one-hot decoder with zero gate
//
// Purpose: turns a CODE_W layer index into a NUM_LAYERS one-hot vector;
//          i_zero forces the output to all zero (empty slot).
// Ports:
//   i_code    in   CODE_W      layer index
//   i_zero    in   1           1 = drive no layer
//   o_onehot  out  NUM_LAYERS  one-hot enable, or all zero
module layer_onehot_dec #(
    parameter int CODE_W     = 3,
    parameter int NUM_LAYERS = 2 ** CODE_W
) (
    input  logic [CODE_W-1:0]     i_code,
    input  logic                  i_zero,
    output logic [NUM_LAYERS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (!i_zero) begin
            o_onehot[i_code] = 1'b1;
        end
    end

endmodule

// File: rtl/layer_select_decoder.sv
// rtl/layer_select_decoder.sv - layer slot sequencer with blank and dwell intervals
//
// Purpose: accepts a {code, z} layer request via valid/ready and lights the
//          decoded layer for DWELL_CYCLES after a BLANK_CYCLES all-off interval.
// Ports:
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           synchronous reset, active low
//   in_code      in   CODE_W      layer index to light
//   in_z         in   1           1 = empty slot, no layer lit
//   in_valid     in   1           request valid
//   in_ready     out  1           request can be accepted (IDLE)
//   layer_en     out  NUM_LAYERS  registered one-hot layer enable, or zero
//   active_code  out  CODE_W      latched index of the slot being served
//   busy         out  1           slot in progress (BLANK or ON)
//   slot_done    out  1           pulse on the last ON cycle
module layer_select_decoder #(
    parameter int CODE_W       = led_cube_pkg::CODE_W,
    parameter int BLANK_CYCLES = led_cube_pkg::DEFAULT_BLANK_CYCLES,
    parameter int DWELL_CYCLES = led_cube_pkg::DEFAULT_DWELL_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CODE_W-1:0]        in_code,
    input  logic                     in_z,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [(2**CODE_W)-1:0]   layer_en,
    output logic [CODE_W-1:0]        active_code,
    output logic                     busy,
    output logic                     slot_done
);

    import led_cube_pkg::*;

    localparam int N_LAYERS = 2 ** CODE_W;
    localparam int CNT_W    = cnt_width(BLANK_CYCLES, DWELL_CYCLES);

    localparam logic [CNT_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] DWELL_LOAD =
        (DWELL_CYCLES > 0) ? CNT_W'(DWELL_CYCLES - 1) : '0;

    layer_state_t          r_state;
    layer_state_t          w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CODE_W-1:0]     r_code;
    logic [CODE_W-1:0]     w_code_nxt;
    logic                  r_z;
    logic                  w_z_nxt;
    logic [N_LAYERS-1:0]   w_dec;
    logic [N_LAYERS-1:0]   r_layer_en;
    logic                  r_busy;
    logic                  r_slot_done;

    // Next-state and counter logic. The counter only decrements while non-zero,
    // so it parks at 0 instead of wrapping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_z_nxt     = r_z;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_code_nxt = in_code;
                    w_z_nxt    = in_z;
                    if (BLANK_CYCLES == 0) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = DWELL_LOAD;
                    end else begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                    end
                end
            end
            ST_BLANK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = DWELL_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Decode from the next-cycle code so the registered enable lines up with
    // the state register; the z flag gates the whole slot dark.
    layer_onehot_dec #(
        .CODE_W     (CODE_W),
        .NUM_LAYERS (N_LAYERS)
    ) u_dec (
        .i_code   (w_code_nxt),
        .i_zero   (w_z_nxt),
        .o_onehot (w_dec)
    );

    // Outputs are registered from the next state, so layer_en can only be
    // non-zero in ON; every slot passes through IDLE, so two layers never overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_code      <= '0;
            r_z         <= 1'b0;
            r_layer_en  <= '0;
            r_busy      <= 1'b0;
            r_slot_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code      <= w_code_nxt;
            r_z         <= w_z_nxt;
            r_layer_en  <= (w_state_nxt == ST_ON) ? w_dec : '0;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_slot_done <= (w_state_nxt == ST_ON) && (w_cnt_nxt == '0);
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign layer_en    = r_layer_en;
    assign active_code = r_code;
    assign busy        = r_busy;
    assign slot_done   = r_slot_done;

endmodule
